// File: rtl/dfp_arbiter.sv
// dfp_arbiter: shares one line-wide memory port between the icache and dcache.
// One requester owns the port per memory transaction; ties are broken round-robin
// against the last winner. Read data fans out to both caches, and only resp
// qualifies it.
module dfp_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              err_proto,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_d_q, last_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_proto_q, err_proto_d;
  logic             err_timeout_q, err_timeout_d;

  logic              i_req_s, d_req_s;
  logic              sel_d_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic              g_read_s, g_write_s;
  logic [LINE_W-1:0] g_wdata_s;

  assign i_req_s = i_read | i_write;
  assign d_req_s = d_read | d_write;

  // Read data goes to both caches unconditionally.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;

  // State, round-robin history, timeout counter and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b1;
      cnt_q         <= {CNT_W{1'b0}};
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      cnt_q         <= cnt_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state logic plus combinational routing of the granted requester.
  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    cnt_d         = cnt_q;
    err_proto_d   = err_proto_q;
    err_timeout_d = err_timeout_q;
    mem_addr      = {ADDR_W{1'b0}};
    mem_wdata     = {LINE_W{1'b0}};
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_resp        = 1'b0;
    d_resp        = 1'b0;

    sel_d_s   = (state_q == BUSY_D);
    g_addr_s  = sel_d_s ? d_addr  : i_addr;
    g_read_s  = sel_d_s ? d_read  : i_read;
    g_write_s = sel_d_s ? d_write : i_write;
    g_wdata_s = sel_d_s ? d_wdata : i_wdata;

    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (i_req_s && d_req_s) begin
          // Tie: the requester that did not win last time goes first.
          state_d = last_d_q ? BUSY_I : BUSY_D;
        end else if (i_req_s) begin
          state_d = BUSY_I;
        end else if (d_req_s) begin
          state_d = BUSY_D;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // A dropped request deasserts the memory strobes, but ownership is
        // kept until memory responds.
        mem_addr  = g_addr_s;
        mem_wdata = g_wdata_s;
        mem_write = g_write_s;
        // Read together with write is illegal: only the write goes through.
        mem_read  = g_read_s & ~g_write_s;
        i_resp    = mem_resp & ~sel_d_s;
        d_resp    = mem_resp & sel_d_s;
        if (g_read_s && g_write_s) begin
          err_proto_d = 1'b1;
        end else begin
          err_proto_d = err_proto_q;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if ((TIMEOUT != 0) && !mem_resp && (cnt_d == CNT_MAX)) begin
          err_timeout_d = 1'b1;
        end else begin
          err_timeout_d = err_timeout_q;
        end
        if (mem_resp) begin
          last_d_d = sel_d_s;
          state_d  = IDLE;
        end else begin
          state_d  = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dfp_arbiter.sv
// Scoreboard bench for dfp_arbiter: directed request queues per cache, a
// small memory model, and a monitor checking every resp against the
// hand-ordered expected grant sequence.
module tb_dfp_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_addr = 32'h0, d_addr = 32'h0, mem_addr;
  logic         i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [255:0] i_wdata = 256'h0, d_wdata = 256'h0, i_rdata, d_rdata, mem_wdata;
  logic [255:0] mem_rdata = 256'h0;
  logic         i_resp, d_resp, mem_read, mem_write, err_proto, err_timeout;
  logic         mem_resp = 1'b0;

  dfp_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } op_t;

  typedef struct packed {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  op_t  iq[$];
  op_t  dq[$];
  exp_t sb[$];

  int   n_chk = 0;
  int   n_err = 0;
  logic i_busy = 1'b0, i_seen = 1'b0, d_busy = 1'b0, d_seen = 1'b0;
  logic hold = 1'b0;
  logic gap_chk = 1'b0;

  localparam logic [255:0] WD_AA = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_0000_1234_5678_9ABC_DEF0_0F0F_00AA;
  localparam logic [255:0] WD_PE = 256'hDEAD_BEEF_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_CAFE_0055;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [255:0] wdata);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  function automatic op_t mk_op(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [255:0] wdata);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  // icache requester: holds each op until its resp, then drops for a cycle.
  task automatic drive_i();
    op_t op;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        i_read = 1'b0; i_write = 1'b0; i_busy = 1'b0; i_seen = 1'b0;
      end else if (i_busy) begin
        if (i_seen) begin
          i_read = 1'b0; i_write = 1'b0; i_busy = 1'b0; i_seen = 1'b0;
        end
      end else if (iq.size() > 0) begin
        op = iq.pop_front();
        i_addr = op.addr; i_read = op.rd; i_write = op.wr; i_wdata = op.wdata;
        i_busy = 1'b1;
      end
    end
  endtask

  // dcache requester, same protocol as the icache one.
  task automatic drive_d();
    op_t op;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0; d_seen = 1'b0;
      end else if (d_busy) begin
        if (d_seen) begin
          d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0; d_seen = 1'b0;
        end
      end else if (dq.size() > 0) begin
        op = dq.pop_front();
        d_addr = op.addr; d_read = op.rd; d_write = op.wr; d_wdata = op.wdata;
        d_busy = 1'b1;
      end
    end
  endtask

  // Memory: answers two cycles after seeing a strobe unless held off.
  task automatic mem_model();
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        mem_resp = 1'b0; cnt = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; cnt = 0;
      end else if ((mem_read || mem_write) && !hold) begin
        cnt++;
        if (cnt >= 2) begin
          mem_resp = 1'b1; mem_rdata = pat(mem_addr); cnt = 0;
        end
      end
    end
  endtask

  // Monitor: every resp pops the scoreboard; the cycle after must be idle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && gap_chk) begin
        chk("idle_gap", {254'h0, mem_read, mem_write}, 256'h0);
      end
      gap_chk = 1'b0;
      if (rst && (i_resp || d_resp)) begin
        gap_chk = 1'b1;
        if (i_resp) i_seen = 1'b1;
        if (d_resp) d_seen = 1'b1;
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_unexpected: got resp i=%0d d=%0d expected none", i_resp, d_resp);
        end else begin
          e = sb.pop_front();
          chk("resp_who",  {255'h0, d_resp}, {255'h0, e.is_d});
          chk("resp_both", {255'h0, i_resp & d_resp}, 256'h0);
          chk("mem_addr",  {224'h0, mem_addr}, {224'h0, e.addr});
          chk("mem_write", {255'h0, mem_write}, {255'h0, e.wr});
          chk("mem_read",  {255'h0, mem_read}, {255'h0, e.rd});
          if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
          else      chk("rdata", e.is_d ? d_rdata : i_rdata, pat(e.addr));
        end
      end
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    do begin
      @(posedge clk); #3;
      k++;
    end while ((sb.size() > 0 || iq.size() > 0 || dq.size() > 0 || i_busy || d_busy) && k < 300);
    if (k >= 300) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_mem_busy();
    int k = 0;
    do begin
      @(posedge clk); #3;
      k++;
    end while (!(mem_read || mem_write) && k < 50);
    if (k >= 50) begin
      n_chk++; n_err++;
      $display("FAIL grant_timeout: got no strobe expected mem_read/mem_write");
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    fork
      drive_i();
      drive_d();
      mem_model();
      monitor();
    join_none

    #1 rst = 1'b0;
    #1;
    chk("rst_mem_read",  {255'h0, mem_read},  256'h0);
    chk("rst_mem_write", {255'h0, mem_write}, 256'h0);
    chk("rst_resp",      {254'h0, i_resp, d_resp}, 256'h0);
    chk("rst_errs",      {254'h0, err_proto, err_timeout}, 256'h0);
    chk("rst_mem_addr",  {224'h0, mem_addr}, 256'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // 1: icache alone, one-cycle grant latency.
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0000, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0000, 256'h0);
    @(posedge clk); #3;
    chk("t1_not_yet", {255'h0, mem_read}, 256'h0);
    @(posedge clk); #3;
    chk("t1_granted", {255'h0, mem_read}, {255'h0, 1'b1});
    chk("t1_addr",    {224'h0, mem_addr}, 256'h0);
    wait_drain();
    chk("t1_idle", {255'h0, mem_read}, 256'h0);

    // 2: ties after reset go icache first, then alternate.
    reset_pulse();
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0020, 256'h0));
    dq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0200, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0020, 256'h0);
    push_exp(1'b1, 1'b1, 1'b0, 32'h0000_0200, 256'h0);
    wait_drain();
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0060, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0060, 256'h0);
    wait_drain();
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0080, 256'h0));
    dq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0280, 256'h0));
    push_exp(1'b1, 1'b1, 1'b0, 32'h0000_0280, 256'h0);
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0080, 256'h0);
    wait_drain();

    // 3: dcache writeback + fill with icache pending: D-w, I-r, D-r.
    dq.push_back(mk_op(1'b0, 1'b1, 32'h0000_0600, WD_AA));
    dq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0400, 256'h0));
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0100, 256'h0));
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_0600, WD_AA);
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0100, 256'h0);
    push_exp(1'b1, 1'b1, 1'b0, 32'h0000_0400, 256'h0);
    wait_drain();
    chk("t3_no_proto", {255'h0, err_proto}, 256'h0);

    // 4: read+write together forwards the write only and latches err_proto.
    dq.push_back(mk_op(1'b1, 1'b1, 32'h0000_0700, WD_PE));
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_0700, WD_PE);
    wait_drain();
    chk("t4_proto", {255'h0, err_proto}, {255'h0, 1'b1});
    chk("t4_no_to", {255'h0, err_timeout}, 256'h0);
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0780, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0780, 256'h0);
    wait_drain();
    chk("t4_sticky", {255'h0, err_proto}, {255'h0, 1'b1});

    // 5: timeout after 8 BUSY cycles, grant held, then normal completion.
    hold = 1'b1;
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0800, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0800, 256'h0);
    wait_mem_busy();
    repeat (7) @(posedge clk);
    #3;
    chk("t5_before", {255'h0, err_timeout}, 256'h0);
    @(posedge clk); #3;
    chk("t5_timeout", {255'h0, err_timeout}, {255'h0, 1'b1});
    chk("t5_held",    {255'h0, mem_read}, {255'h0, 1'b1});
    hold = 1'b0;
    wait_drain();
    chk("t5_sticky", {255'h0, err_timeout}, {255'h0, 1'b1});

    // 6: async reset during BUSY_D clears outputs without a clock edge.
    hold = 1'b1;
    dq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0900, 256'h0));
    wait_mem_busy();
    mem_resp = 1'b1;
    #1;
    chk("t6_pre_resp", {255'h0, d_resp}, {255'h0, 1'b1});
    chk("t6_pre_errs", {254'h0, err_proto, err_timeout}, {254'h0, 2'b11});
    rst = 1'b0;
    #1;
    chk("t6_resp",     {254'h0, i_resp, d_resp}, 256'h0);
    chk("t6_mem_read", {255'h0, mem_read}, 256'h0);
    chk("t6_errs",     {254'h0, err_proto, err_timeout}, 256'h0);
    mem_resp = 1'b0;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    iq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0A00, 256'h0));
    dq.push_back(mk_op(1'b1, 1'b0, 32'h0000_0A20, 256'h0));
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 256'h0);
    push_exp(1'b1, 1'b1, 1'b0, 32'h0000_0A20, 256'h0);
    wait_drain();
    chk("t6_errs_after", {254'h0, err_proto, err_timeout}, 256'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
